// File: rtl/pong_game_state_pkg.sv
// Shared pong game parameters, FSM state encodings and small helpers.
// Geometry constants are pre-sized to the widths used by the engine compares.
package pong_game_state_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int PAD_DISTANCE  = 16;
    localparam int PAD_WIDTH     = 8;
    localparam int PAD_HEIGHT    = 64;
    localparam int BALL_SIZE     = 8;
    localparam int PAD_SPEED     = 4;
    localparam int BALL_SPEED    = 2;
    localparam int SERVE_FRAMES  = 60;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        POINT = 2'd2
    } state_t;

    // pad centre limits, one bit wider than the 9-bit pad position
    localparam logic [9:0] PAD_MIN  = 10'(PAD_HEIGHT / 2);
    localparam logic [9:0] PAD_MAX  = 10'(SCREEN_HEIGHT - PAD_HEIGHT / 2);
    localparam logic [9:0] PAD_STEP = 10'(PAD_SPEED);

    // horizontal geometry, 11 bits
    localparam logic [10:0] X_HB     = 11'(BALL_SIZE / 2);
    localparam logic [10:0] X_FACE_R = 11'(SCREEN_WIDTH - PAD_DISTANCE - PAD_WIDTH);
    localparam logic [10:0] X_OUT_R  = 11'(SCREEN_WIDTH - PAD_DISTANCE);
    localparam logic [10:0] X_FACE_L = 11'(PAD_DISTANCE + PAD_WIDTH);
    localparam logic [10:0] X_OUT_L  = 11'(PAD_DISTANCE);
    localparam logic [10:0] X_EDGE_R = 11'(SCREEN_WIDTH - 1);
    localparam logic [10:0] X_SNAP_R = X_FACE_R - X_HB;
    localparam logic [10:0] X_SNAP_L = X_FACE_L + X_HB;
    localparam logic [10:0] X_MISS_R = X_EDGE_R - X_HB;
    localparam logic [10:0] X_CTR    = 11'(SCREEN_WIDTH / 2);

    // vertical geometry, 10 bits
    localparam logic [9:0] Y_HB    = 10'(BALL_SIZE / 2);
    localparam logic [9:0] Y_BOT   = 10'(SCREEN_HEIGHT - BALL_SIZE / 2);
    localparam logic [9:0] Y_REACH = 10'((PAD_HEIGHT + BALL_SIZE) / 2);
    localparam logic [9:0] Y_CTR   = 10'(SCREEN_HEIGHT / 2);

    localparam logic [5:0] SERVE_LAST = 6'(SERVE_FRAMES - 1);
    localparam logic [2:0] SPEED_INIT = 3'(BALL_SPEED);

    // one BCD digit increment, 9 rolls over to 0
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/pong_game_state_pad.sv
// Clamped vertical pad mover, advanced once per frame tick.
// Limits are compared before stepping so the centre never wraps.
module pong_pad_mover
    import pong_game_state_pkg::*;
(
    input  logic       clk_vga,
    input  logic       rst,
    input  logic       tick,
    input  logic       up,
    input  logic       dn,
    output logic [8:0] pos
);

    logic [9:0] cur;
    logic [8:0] nxt;

    assign cur = {1'b0, pos};

    // next centre: one step toward the pressed button, held at the limits
    always_comb begin
        nxt = pos;
        if (up && !dn) begin
            if (cur <= PAD_MIN + PAD_STEP)
                nxt = PAD_MIN[8:0];
            else
                nxt = pos - PAD_STEP[8:0];
        end else if (dn && !up) begin
            if (cur + PAD_STEP >= PAD_MAX)
                nxt = PAD_MAX[8:0];
            else
                nxt = pos + PAD_STEP[8:0];
        end
    end

    // pad centre register, moves only on a frame tick
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst)
            pos <= Y_CTR[8:0];
        else if (tick)
            pos <= nxt;
    end

endmodule

// File: rtl/pong_game_state.sv
// Pong frame-rate engine: pads, ball, serve/play/point FSM and scores.
// Optional macro BALL_SPEEDUP_EN: ball speeds up every fourth pad hit.
module pong_game_state
    import pong_game_state_pkg::*;
(
    input  logic       clk_vga,
    input  logic       rst,
    input  logic       vga_vs_n,
    input  logic       btn_left_up,
    input  logic       btn_left_dn,
    input  logic       btn_right_up,
    input  logic       btn_right_dn,
    output logic [8:0] pad_left,
    output logic [8:0] pad_right,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       serving
);

    state_t     state;
    logic       vs_prev;
    logic       tick;
    logic [5:0] frame_cnt;
    logic       dx;
    logic       dy;
    logic [2:0] speed;
    logic       left_scored;
`ifdef BALL_SPEEDUP_EN
    localparam logic [2:0] SPEED_MAX = 3'd6;
    logic [1:0] hit_cnt;
`endif

    logic [10:0] bx;
    logic [10:0] sx;
    logic [9:0]  by;
    logic [9:0]  sy;
    logic [9:0]  dl;
    logic [9:0]  dr;
    logic [9:0]  x_step;
    logic [8:0]  y_step;
    logic        hit_l;
    logic        hit_r;
    logic        miss_l;
    logic        miss_r;
    logic        wall_t;
    logic        wall_b;

    assign tick = vs_prev & ~vga_vs_n;
    assign bx   = {1'b0, ball_x};
    assign by   = {1'b0, ball_y};
    assign sx   = {8'd0, speed};
    assign sy   = {7'd0, speed};

    pong_pad_mover u_pad_left (
        .clk_vga (clk_vga),
        .rst     (rst),
        .tick    (tick),
        .up      (btn_left_up),
        .dn      (btn_left_dn),
        .pos     (pad_left)
    );

    pong_pad_mover u_pad_right (
        .clk_vga (clk_vga),
        .rst     (rst),
        .tick    (tick),
        .up      (btn_right_up),
        .dn      (btn_right_dn),
        .pos     (pad_right)
    );

    // collision, wall and miss detection against pre-tick positions
    always_comb begin
        dl = (by >= {1'b0, pad_left})
           ? by - {1'b0, pad_left} : {1'b0, pad_left} - by;
        dr = (by >= {1'b0, pad_right})
           ? by - {1'b0, pad_right} : {1'b0, pad_right} - by;
        hit_r  = dx && (bx + X_HB + sx >= X_FACE_R)
                    && (bx + X_HB <= X_OUT_R) && (dr < Y_REACH);
        hit_l  = !dx && (bx <= X_FACE_L + X_HB + sx)
                     && (bx >= X_OUT_L + X_HB) && (dl < Y_REACH);
        miss_r = dx && (bx + X_HB + sx >= X_EDGE_R);
        miss_l = !dx && (bx <= X_HB + sx);
        wall_t = !dy && (by <= Y_HB + sy);
        wall_b = dy && (by + sy >= Y_BOT);
        x_step = dx ? ball_x + 10'(speed) : ball_x - 10'(speed);
        y_step = dy ? ball_y + 9'(speed) : ball_y - 9'(speed);
    end

    // game FSM: all state advances on the frame tick only
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            vs_prev     <= 1'b1;
            state       <= SERVE;
            frame_cnt   <= 6'd0;
            ball_x      <= X_CTR[9:0];
            ball_y      <= Y_CTR[8:0];
            dx          <= 1'b1;
            dy          <= 1'b1;
            speed       <= SPEED_INIT;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            left_scored <= 1'b0;
            serving     <= 1'b1;
`ifdef BALL_SPEEDUP_EN
            hit_cnt     <= 2'd0;
`endif
        end else begin
            vs_prev <= vga_vs_n;
            if (tick) begin
                unique case (state)
                    SERVE: begin
                        if (frame_cnt == SERVE_LAST) begin
                            state     <= PLAY;
                            frame_cnt <= 6'd0;
                            serving   <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + 6'd1;
                        end
                    end
                    PLAY: begin
                        if (wall_t) begin
                            ball_y <= Y_HB[8:0];
                            dy     <= 1'b1;
                        end else if (wall_b) begin
                            ball_y <= Y_BOT[8:0];
                            dy     <= 1'b0;
                        end else begin
                            ball_y <= y_step;
                        end
                        if (hit_r) begin
                            ball_x <= X_SNAP_R[9:0];
                            dx     <= 1'b0;
                        end else if (hit_l) begin
                            ball_x <= X_SNAP_L[9:0];
                            dx     <= 1'b1;
                        end else if (miss_r) begin
                            ball_x      <= X_MISS_R[9:0];
                            state       <= POINT;
                            left_scored <= 1'b1;
                        end else if (miss_l) begin
                            ball_x      <= X_HB[9:0];
                            state       <= POINT;
                            left_scored <= 1'b0;
                        end else begin
                            ball_x <= x_step;
                        end
`ifdef BALL_SPEEDUP_EN
                        if (hit_r || hit_l) begin
                            hit_cnt <= hit_cnt + 2'd1;
                            if (hit_cnt == 2'd3 && speed != SPEED_MAX)
                                speed <= speed + 3'd1;
                        end
`endif
                    end
                    POINT: begin
                        if (left_scored)
                            score_left <= bcd_inc(score_left);
                        else
                            score_right <= bcd_inc(score_right);
                        ball_x    <= X_CTR[9:0];
                        ball_y    <= Y_CTR[8:0];
                        dx        <= left_scored;
                        speed     <= SPEED_INIT;
                        frame_cnt <= 6'd0;
                        state     <= SERVE;
                        serving   <= 1'b1;
`ifdef BALL_SPEEDUP_EN
                        hit_cnt   <= 2'd0;
`endif
                    end
                    default: begin
                        state   <= SERVE;
                        serving <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pong_game_state.sv
// Directed bench for pong_game_state: serve, walls, pad hit, misses,
// score wrap, asynchronous reset and pad clamping.
module tb_pong_game_state;

    logic       clk_vga = 1'b0;
    logic       rst = 1'b1;
    logic       vga_vs_n = 1'b1;
    logic       btn_left_up = 1'b0;
    logic       btn_left_dn = 1'b0;
    logic       btn_right_up = 1'b0;
    logic       btn_right_dn = 1'b0;
    logic [8:0] pad_left;
    logic [8:0] pad_right;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       serving;

    int checks = 0;
    int passed = 0;

    pong_game_state dut (
        .clk_vga      (clk_vga),
        .rst          (rst),
        .vga_vs_n     (vga_vs_n),
        .btn_left_up  (btn_left_up),
        .btn_left_dn  (btn_left_dn),
        .btn_right_up (btn_right_up),
        .btn_right_dn (btn_right_dn),
        .pad_left     (pad_left),
        .pad_right    (pad_right),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .score_left   (score_left),
        .score_right  (score_right),
        .serving      (serving)
    );

    always #5 clk_vga = ~clk_vga;

    // one frame: vs low for one clock, then back high; returns at a negedge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_vga);
            vga_vs_n = 1'b0;
            @(negedge clk_vga);
            vga_vs_n = 1'b1;
            @(negedge clk_vga);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_vga);
        rst = 1'b1;
        repeat (3) @(negedge clk_vga);
        rst = 1'b0;
        @(negedge clk_vga);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pad_left, pad_right} !== {9'd240, 9'd240})
            $display("FAIL reset_pads got %0d,%0d want 240,240",
                     pad_left, pad_right);
        else passed++;
        checks++;
        if ({ball_x, ball_y} !== {10'd320, 9'd240})
            $display("FAIL reset_ball got %0d,%0d want 320,240",
                     ball_x, ball_y);
        else passed++;
        checks++;
        if ({score_left, score_right, serving} !== 9'b0000_0000_1)
            $display("FAIL reset_score got %0d,%0d,%0b want 0,0,1",
                     score_left, score_right, serving);
        else passed++;
    endtask

    task automatic test_serve();
        for (int i = 1; i <= 59; i++) begin
            tick(1);
            checks++;
            if (serving !== 1'b1)
                $display("FAIL serve_hold tick %0d got %0b want 1",
                         i, serving);
            else passed++;
        end
        tick(1);
        checks++;
        if ({serving, ball_x, ball_y} !== {1'b0, 10'd320, 9'd240})
            $display("FAIL serve_end got %0b,%0d,%0d want 0,320,240",
                     serving, ball_x, ball_y);
        else passed++;
        tick(1);
        checks++;
        if ({ball_x, ball_y} !== {10'd322, 9'd242})
            $display("FAIL play_p1 got %0d,%0d want 322,242",
                     ball_x, ball_y);
        else passed++;
        repeat (8) @(negedge clk_vga);
        checks++;
        if ({ball_x, ball_y} !== {10'd322, 9'd242})
            $display("FAIL idle_hold got %0d,%0d want 322,242",
                     ball_x, ball_y);
        else passed++;
        tick(1);
        checks++;
        if ({ball_x, ball_y} !== {10'd324, 9'd244})
            $display("FAIL play_p2 got %0d,%0d want 324,244",
                     ball_x, ball_y);
        else passed++;
    endtask

    task automatic test_bottom_wall();
        tick(115);
        checks++;
        if (ball_y !== 9'd474)
            $display("FAIL bot_p117 got %0d want 474", ball_y);
        else passed++;
        tick(1);
        checks++;
        if (ball_y !== 9'd476)
            $display("FAIL bot_p118 got %0d want 476", ball_y);
        else passed++;
        tick(1);
        checks++;
        if ({ball_x, ball_y} !== {10'd558, 9'd474})
            $display("FAIL bot_p119 got %0d,%0d want 558,474",
                     ball_x, ball_y);
        else passed++;
    endtask

    task automatic test_right_miss();
        tick(38);
        checks++;
        if (ball_x !== 10'd634)
            $display("FAIL miss_p157 got %0d want 634", ball_x);
        else passed++;
        tick(1);
        checks++;
        if ({ball_x, serving, score_left} !== {10'd635, 1'b0, 4'd0})
            $display("FAIL miss_p158 got %0d,%0b,%0d want 635,0,0",
                     ball_x, serving, score_left);
        else passed++;
        tick(1);
        checks++;
        if ({score_left, score_right} !== {4'd1, 4'd0})
            $display("FAIL point_score got %0d,%0d want 1,0",
                     score_left, score_right);
        else passed++;
        checks++;
        if ({ball_x, ball_y, serving} !== {10'd320, 9'd240, 1'b1})
            $display("FAIL point_ball got %0d,%0d,%0b want 320,240,1",
                     ball_x, ball_y, serving);
        else passed++;
    endtask

    task automatic test_top_wall();
        tick(61);
        checks++;
        if ({ball_x, ball_y} !== {10'd322, 9'd238})
            $display("FAIL r2_p1 got %0d,%0d want 322,238",
                     ball_x, ball_y);
        else passed++;
        tick(116);
        checks++;
        if (ball_y !== 9'd6)
            $display("FAIL top_p117 got %0d want 6", ball_y);
        else passed++;
        tick(1);
        checks++;
        if (ball_y !== 9'd4)
            $display("FAIL top_p118 got %0d want 4", ball_y);
        else passed++;
        tick(1);
        checks++;
        if (ball_y !== 9'd6)
            $display("FAIL top_p119 got %0d want 6", ball_y);
        else passed++;
        tick(40);
        checks++;
        if ({score_left, serving} !== {4'd2, 1'b1})
            $display("FAIL r2_score got %0d,%0b want 2,1",
                     score_left, serving);
        else passed++;
    endtask

    task automatic test_score_wrap();
        tick(219 * 7);
        checks++;
        if ({score_left, score_right} !== {4'd9, 4'd0})
            $display("FAIL score_nine got %0d,%0d want 9,0",
                     score_left, score_right);
        else passed++;
        tick(219);
        checks++;
        if ({score_left, score_right} !== {4'd0, 4'd0})
            $display("FAIL score_wrap got %0d,%0d want 0,0",
                     score_left, score_right);
        else passed++;
    endtask

    task automatic test_async_reset();
        tick(70);
        checks++;
        if ({ball_x, serving} !== {10'd340, 1'b0})
            $display("FAIL pre_rst got %0d,%0b want 340,0",
                     ball_x, serving);
        else passed++;
        @(negedge clk_vga);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ball_x, ball_y, serving} !== {10'd320, 9'd240, 1'b1})
            $display("FAIL async_ball got %0d,%0d,%0b want 320,240,1",
                     ball_x, ball_y, serving);
        else passed++;
        checks++;
        if ({score_left, score_right, pad_left, pad_right}
            !== {4'd0, 4'd0, 9'd240, 9'd240})
            $display("FAIL async_rest got %0d,%0d,%0d,%0d want 0,0,240,240",
                     score_left, score_right, pad_left, pad_right);
        else passed++;
        @(negedge clk_vga);
        rst = 1'b0;
        @(negedge clk_vga);
    endtask

    task automatic test_pad_hit();
        btn_right_dn = 1'b1;
        tick(205);
        checks++;
        if ({ball_x, pad_right} !== {10'd610, 9'd448})
            $display("FAIL hit_pre got %0d,%0d want 610,448",
                     ball_x, pad_right);
        else passed++;
        tick(1);
        checks++;
        if (ball_x !== 10'd612)
            $display("FAIL hit_snap got %0d want 612", ball_x);
        else passed++;
        tick(1);
        checks++;
        if (ball_x !== 10'd610)
            $display("FAIL hit_step got %0d want 610", ball_x);
        else passed++;
        tick(302);
        checks++;
        if (ball_x !== 10'd6)
            $display("FAIL lmiss_p449 got %0d want 6", ball_x);
        else passed++;
        tick(1);
        checks++;
        if ({ball_x, serving} !== {10'd4, 1'b0})
            $display("FAIL lmiss_p450 got %0d,%0b want 4,0",
                     ball_x, serving);
        else passed++;
        tick(1);
        checks++;
        if ({score_left, score_right, serving} !== {4'd0, 4'd1, 1'b1})
            $display("FAIL rpoint got %0d,%0d,%0b want 0,1,1",
                     score_left, score_right, serving);
        else passed++;
        tick(61);
        checks++;
        if ({ball_x, ball_y} !== {10'd318, 9'd242})
            $display("FAIL serve_left got %0d,%0d want 318,242",
                     ball_x, ball_y);
        else passed++;
        btn_right_dn = 1'b0;
    endtask

    task automatic test_pads();
        do_reset();
        btn_left_up = 1'b1;
        tick(1);
        checks++;
        if (pad_left !== 9'd236)
            $display("FAIL pad_up1 got %0d want 236", pad_left);
        else passed++;
        tick(1);
        checks++;
        if (pad_left !== 9'd232)
            $display("FAIL pad_up2 got %0d want 232", pad_left);
        else passed++;
        tick(50);
        checks++;
        if (pad_left !== 9'd32)
            $display("FAIL pad_top got %0d want 32", pad_left);
        else passed++;
        tick(48);
        checks++;
        if ({pad_left, pad_right} !== {9'd32, 9'd240})
            $display("FAIL pad_top_hold got %0d,%0d want 32,240",
                     pad_left, pad_right);
        else passed++;
        btn_left_dn = 1'b1;
        tick(5);
        checks++;
        if (pad_left !== 9'd32)
            $display("FAIL pad_both got %0d want 32", pad_left);
        else passed++;
        btn_left_up = 1'b0;
        tick(1);
        checks++;
        if (pad_left !== 9'd36)
            $display("FAIL pad_dn1 got %0d want 36", pad_left);
        else passed++;
        tick(103);
        checks++;
        if (pad_left !== 9'd448)
            $display("FAIL pad_bot got %0d want 448", pad_left);
        else passed++;
        tick(1);
        checks++;
        if (pad_left !== 9'd448)
            $display("FAIL pad_bot_hold got %0d want 448", pad_left);
        else passed++;
        btn_left_dn = 1'b0;
        btn_right_up = 1'b1;
        tick(1);
        checks++;
        if ({pad_right, pad_left} !== {9'd236, 9'd448})
            $display("FAIL pad_right_up got %0d,%0d want 236,448",
                     pad_right, pad_left);
        else passed++;
        btn_right_up = 1'b0;
    endtask

    initial begin
        test_reset();
        test_serve();
        test_bottom_wall();
        test_right_miss();
        test_top_wall();
        test_score_wrap();
        test_async_reset();
        test_pad_hit();
        test_pads();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
